// File: rtl/sine_voice_pkg.sv
// Shared types, constants and the quarter-wave LUT generator for the sine voice mixer.
package sine_voice_pkg;

    localparam int DEF_N_VOICES = 16;
    localparam int DEF_PHASE_W  = 24;
    localparam int DEF_LUT_AW   = 5;
    localparam int DEF_OUT_W    = 16;
    localparam int DEF_VW       = $clog2(DEF_N_VOICES);
    localparam int ENV_STEP     = 8;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

    typedef struct packed {
        logic [DEF_VW-1:0]      voice;
        logic                   on;
        logic [DEF_PHASE_W-1:0] inc;
        logic [1:0]             vol;
    } evt_t;

    localparam longint PI_HALF_Q30 = 64'sd1686629713;

    // Integer Taylor series in Q30 so the ROM contents elaborate without real-number support.
    function automatic int sine_lut_val(input int i, input int aw, input int out_w);
        longint x, x2, term, acc;
        x    = (PI_HALF_Q30 * longint'(i)) >>> aw;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return int'(((acc <<< (out_w - 2)) + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM (first quadrant magnitudes) with a one-cycle registered read.
module sine_quarter_lut
    import sine_voice_pkg::*;
#(
    parameter int LUT_AW = 5,
    parameter int OUT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [OUT_W-2:0]  o_data
);

    logic [OUT_W-2:0] w_rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam int VAL = sine_lut_val(g, LUT_AW, OUT_W);
        assign w_rom[g] = (OUT_W - 1)'(VAL);
    end

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_data <= '0;
        else          o_data <= w_rom[i_addr];
    end

endmodule

// File: rtl/sine_voice_mixer.sv
// Time-multiplexed N-voice sine synthesiser and saturating mixer, one sample per i_sample_tick.
// Optional per-voice attack/release envelope: define SINE_VOICE_ENV_RAMP_EN.
module sine_voice_mixer
    import sine_voice_pkg::*;
#(
    parameter  int N_VOICES = DEF_N_VOICES,
    parameter  int PHASE_W  = DEF_PHASE_W,
    parameter  int LUT_AW   = DEF_LUT_AW,
    parameter  int OUT_W    = DEF_OUT_W,
    localparam int VW       = $clog2(N_VOICES)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_evt_valid,
    output logic                    o_evt_ready,
    input  logic [VW-1:0]           i_evt_voice,
    input  logic                    i_evt_on,
    input  logic [PHASE_W-1:0]      i_evt_inc,
    input  logic [1:0]              i_evt_vol,
    input  logic                    i_sample_tick,
    output logic signed [OUT_W-1:0] o_sample,
    output logic                    o_sample_valid,
    output logic                    o_busy,
    output logic                    o_overrun
);

    localparam int ACC_W = OUT_W + VW;
`ifdef SINE_VOICE_ENV_RAMP_EN
    localparam int DRAIN_CYC = 3;
`else
    localparam int DRAIN_CYC = 2;
`endif
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_OUT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [VW-1:0]           r_cnt;
    logic [1:0]              r_drain;
    logic                    r_en    [N_VOICES];
    logic [PHASE_W-1:0]      r_phase [N_VOICES];
    logic [PHASE_W-1:0]      r_inc   [N_VOICES];
    logic [1:0]              r_vol   [N_VOICES];
    logic                    w_idle, w_scan, w_evt_fire;
    quadrant_t               w_quad;
    logic [LUT_AW-1:0]       w_idx, w_addr;
    logic [OUT_W-2:0]        w_lut;
    logic                    r_s1_valid, r_s1_neg;
    logic [1:0]              r_s1_vol;
    logic signed [OUT_W-1:0] w_val, w_add, w_sat;
    logic [1:0]              w_add_vol;
    logic                    w_add_valid;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [OUT_W-1:0] r_sample;
    logic                    r_valid, r_overrun;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        o_evt_ready = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_evt_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_sample_tick) w_state_nxt = S_SCAN;
            end
            S_SCAN:  if (r_cnt == VW'(N_VOICES - 1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain == 2'(DRAIN_CYC - 1)) w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_idle     = (r_state == S_IDLE);
    assign w_scan     = (r_state == S_SCAN);
    assign w_evt_fire = i_evt_valid && w_idle;

    assign w_quad = quadrant_t'(r_phase[r_cnt][PHASE_W-1 -: 2]);
    assign w_idx  = r_phase[r_cnt][PHASE_W-3 -: LUT_AW];
    assign w_addr = (w_quad == Q1 || w_quad == Q3) ? ~w_idx : w_idx;

    sine_quarter_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_addr  (w_addr),
        .o_data  (w_lut)
    );

`ifdef SINE_VOICE_ENV_RAMP_EN
    logic [7:0]              r_env [N_VOICES];
    logic                    r_rel [N_VOICES];
    logic [7:0]              r_s1_env;
    logic signed [OUT_W+8:0] w_prod;
    logic signed [OUT_W-1:0] r_s2_val;
    logic [1:0]              r_s2_vol;
    logic                    r_s2_valid;
`endif

    // NOTE: voice state is reset explicitly; a note must never start from stale phase or gain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < N_VOICES; v++) begin
                r_en[v]    <= 1'b0;
                r_phase[v] <= '0;
                r_inc[v]   <= '0;
                r_vol[v]   <= '0;
`ifdef SINE_VOICE_ENV_RAMP_EN
                r_env[v]   <= '0;
                r_rel[v]   <= 1'b0;
`endif
            end
        end else if (w_evt_fire) begin
            if (i_evt_on) begin
                r_en[i_evt_voice]    <= 1'b1;
                r_phase[i_evt_voice] <= '0;
                r_inc[i_evt_voice]   <= i_evt_inc;
                r_vol[i_evt_voice]   <= i_evt_vol;
`ifdef SINE_VOICE_ENV_RAMP_EN
                r_env[i_evt_voice]   <= '0;
                r_rel[i_evt_voice]   <= 1'b0;
            end else begin
                r_rel[i_evt_voice]   <= 1'b1;
`else
            end else begin
                r_en[i_evt_voice]    <= 1'b0;
`endif
            end
        end else if (w_scan && r_en[r_cnt]) begin
            r_phase[r_cnt] <= r_phase[r_cnt] + r_inc[r_cnt];
`ifdef SINE_VOICE_ENV_RAMP_EN
            // Release ends the note once the envelope has decayed to zero.
            if (!r_rel[r_cnt]) begin
                r_env[r_cnt] <= (r_env[r_cnt] > 8'(255 - ENV_STEP)) ? 8'hFF
                                                                     : r_env[r_cnt] + 8'(ENV_STEP);
            end else if (r_env[r_cnt] <= 8'(ENV_STEP)) begin
                r_env[r_cnt] <= '0;
                r_en[r_cnt]  <= 1'b0;
            end else begin
                r_env[r_cnt] <= r_env[r_cnt] - 8'(ENV_STEP);
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_vol   <= '0;
        end else begin
            r_s1_valid <= w_scan && r_en[r_cnt];
            r_s1_neg   <= (w_quad == Q2) || (w_quad == Q3);
            r_s1_vol   <= r_vol[r_cnt];
        end
    end

    assign w_val = r_s1_neg ? -$signed({1'b0, w_lut}) : $signed({1'b0, w_lut});

`ifdef SINE_VOICE_ENV_RAMP_EN
    assign w_prod = w_val * $signed({1'b0, r_s1_env});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_env   <= '0;
            r_s2_val   <= '0;
            r_s2_vol   <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_env   <= r_env[r_cnt];
            r_s2_val   <= OUT_W'(w_prod >>> 8);
            r_s2_vol   <= r_s1_vol;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign w_add       = r_s2_val;
    assign w_add_vol   = r_s2_vol;
    assign w_add_valid = r_s2_valid;
`else
    assign w_add       = w_val;
    assign w_add_vol   = r_s1_vol;
    assign w_add_valid = r_s1_valid;
`endif

    assign w_sat = (r_acc > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                   (r_acc < SAT_LO) ? SAT_LO[OUT_W-1:0] : r_acc[OUT_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_drain   <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (r_state == S_OUT);
            r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
            if (i_sample_tick && !w_idle) r_overrun <= 1'b1;
            if (w_scan) r_cnt <= (r_cnt == VW'(N_VOICES - 1)) ? '0 : r_cnt + 1'b1;
            if (w_idle && i_sample_tick) r_acc <= '0;
            else if (w_add_valid)        r_acc <= r_acc + ACC_W'(w_add >>> w_add_vol);
            if (r_state == S_OUT) r_sample <= w_sat;
        end
    end

    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_sine_voice_mixer.sv
// Directed self-checking bench for sine_voice_mixer at default parameters (envelope off).
module tb_sine_voice_mixer;
    import sine_voice_pkg::*;

    localparam int LAT = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic [3:0]  evt_voice = '0;
    logic        evt_on = 1'b0;
    logic [23:0] evt_inc = '0;
    logic [1:0]  evt_vol = '0;
    logic        tick = 1'b0;
    logic        o_evt_ready;
    logic [15:0] o_sample;
    logic        o_sample_valid;
    logic        o_busy;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;

    sine_voice_mixer #(.N_VOICES(16), .PHASE_W(24), .LUT_AW(5), .OUT_W(16)) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_evt_valid    (evt_valid),
        .o_evt_ready    (o_evt_ready),
        .i_evt_voice    (evt_voice),
        .i_evt_on       (evt_on),
        .i_evt_inc      (evt_inc),
        .i_evt_vol      (evt_vol),
        .i_sample_tick  (tick),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic evt_t mk_evt(input int voice, input bit on, input int inc, input int vol);
        evt_t e;
        e.voice = 4'(voice);
        e.on    = on;
        e.inc   = 24'(inc);
        e.vol   = 2'(vol);
        return e;
    endfunction

    task automatic drive_evt(input evt_t e);
        evt_valid = 1'b1;
        evt_voice = e.voice;
        evt_on    = e.on;
        evt_inc   = e.inc;
        evt_vol   = e.vol;
    endtask

    task automatic send_evt(input evt_t e);
        @(negedge clk);
        drive_evt(e);
        check("evt_ready_idle", {31'd0, o_evt_ready}, 32'd1);
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    // One tick; returns the produced sample and checks latency and single-cycle pulse.
    task automatic tick_once(output logic [15:0] smp);
        int lat;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat = 1;
        while (!o_sample_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        smp = o_sample;
        check("tick_latency", 32'(lat - 1), 32'(LAT));
        @(negedge clk);
        check("valid_one_pulse", {31'd0, o_sample_valid}, 32'd0);
    endtask

    task automatic advance(input int n, output logic [15:0] smp);
        smp = '0;
        for (int t = 0; t < n; t++) tick_once(smp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        evt_valid = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] s;
    int nval;
    int acc_cnt;
    bit drop;

    initial begin
        // 1: reset state and empty mix
        #12;
        check("rst_sample", {16'd0, o_sample}, 32'd0);
        check("rst_valid", {31'd0, o_sample_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_overrun", {31'd0, o_overrun}, 32'd0);
        check("rst_ready", {31'd0, o_evt_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick_once(s);
            check("empty_mix", {16'd0, s}, 32'd0);
        end

        // 2: single voice, full volume
        send_evt(mk_evt(0, 1'b1, 32'h020000, 0));
        advance(1, s);  check("v0_tick1", {16'd0, s}, 32'h0000);
        advance(1, s);  check("v0_tick2", {16'd0, s}, 32'h0324);
        advance(31, s); check("v0_tick33", {16'd0, s}, 32'h3FEC);
        advance(64, s); check("v0_tick97", {16'd0, s}, 32'hC014);

        // 3: restart with vol=2
        send_evt(mk_evt(0, 1'b1, 32'h020000, 2));
        advance(1, s);  check("vol2_tick1", {16'd0, s}, 32'h0000);
        advance(1, s);  check("vol2_tick2", {16'd0, s}, 32'h00C9);

        // 4: all voices, saturation both ways
        for (int v = 0; v < 16; v++) send_evt(mk_evt(v, 1'b1, 32'h020000, 0));
        advance(1, s);  check("all_tick1", {16'd0, s}, 32'h0000);
        advance(1, s);  check("all_tick2", {16'd0, s}, 32'h3240);
        advance(31, s); check("all_tick33_sat", {16'd0, s}, 32'h7FFF);
        advance(64, s); check("all_tick97_sat", {16'd0, s}, 32'h8000);

        // 5: tick while busy, event held through the scan
        apply_reset();
        check("ovr_clear", {31'd0, o_overrun}, 32'd0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        drive_evt(mk_evt(0, 1'b1, 32'h020000, 0));
        check("busy_2nd_tick", {31'd0, o_busy}, 32'd1);
        check("ready_busy", {31'd0, o_evt_ready}, 32'd0);
        @(negedge clk); tick = 1'b0;
        check("ovr_set", {31'd0, o_overrun}, 32'd1);
        nval = 0;
        acc_cnt = 0;
        drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (drop) begin
                evt_valid = 1'b0;
                drop = 1'b0;
            end
            if (o_sample_valid) nval++;
            if (evt_valid && o_evt_ready) begin
                acc_cnt++;
                check("evt_with_valid", {31'd0, o_sample_valid}, 32'd1);
                drop = 1'b1;
            end
        end
        check("ovr_one_valid", 32'(nval), 32'd1);
        check("held_evt_taken", 32'(acc_cnt), 32'd1);
        check("ovr_sticky", {31'd0, o_overrun}, 32'd1);
        advance(1, s); check("held_v0_tick1", {16'd0, s}, 32'h0000);
        advance(1, s); check("held_v0_tick2", {16'd0, s}, 32'h0324);

        // note-off in the same cycle as a tick is seen by that scan
        @(negedge clk);
        drive_evt(mk_evt(0, 1'b0, 0, 0));
        tick = 1'b1;
        @(negedge clk);
        evt_valid = 1'b0;
        tick = 1'b0;
        nval = 0;
        while (!o_sample_valid && nval < 40) begin
            @(negedge clk);
            nval++;
        end
        check("same_cycle_off", {16'd0, o_sample}, 32'h0000);

        // 6: reset mid-scan
        send_evt(mk_evt(0, 1'b1, 32'h020000, 0));
        advance(2, s); check("pre_rst_tick2", {16'd0, s}, 32'h0324);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_scan_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_sample", {16'd0, o_sample}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_overrun", {31'd0, o_overrun}, 32'd0);
        check("midrst_ready", {31'd0, o_evt_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_sample_valid) nval++;
        end
        check("no_partial_sample", 32'(nval), 32'd0);
        advance(1, s); check("post_rst_tick", {16'd0, s}, 32'h0000);
        advance(1, s); check("post_rst_voice_off", {16'd0, s}, 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
